// File: rtl/pc_pred_seg_chain.sv
// Purpose: DEPTH-stage PC/prediction segment chain with branch-prediction check and statistics at the tail.
// Latency: DEPTH clock edges from stage-0 inputs to tail outputs; resolution outputs are combinational from the tail.
// Backpressure: bubble[k] holds stage k (and beats flush[k]); earlier stages are not stalled, so upstream must bubble them too.
module pc_pred_seg_chain #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2,
    parameter int BHT_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] bubble,
    input  logic [DEPTH-1:0] flush,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             valid_in,
    input  logic             pred_taken_in,
    input  logic [PC_W-1:0]  pred_target_in,
    input  logic [BHT_W-1:0] bht_in,
    output logic [PC_W-1:0]  pc_out,
    output logic             valid_out,
    output logic             pred_taken_out,
    output logic [PC_W-1:0]  pred_target_out,
    output logic [BHT_W-1:0] bht_out,
    input  logic             br_resolve,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [BHT_W-1:0] bht_next,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    // One segment entry; all fields travel together through the chain.
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [PC_W-1:0]  target;
        logic [BHT_W-1:0] bht;
        logic             pred_taken;
        logic             valid;
    } seg_t;

    localparam int               TAIL    = DEPTH - 1;
    localparam logic [BHT_W-1:0] BHT_MAX = {BHT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    seg_t seg_q   [DEPTH];
    seg_t seg_src [DEPTH];
    seg_t tail;
    logic chk;
    logic consume;

    // Each stage loads from the input bundle (stage 0) or from the stage before it.
    always_comb begin
        seg_src[0].pc         = pc_in;
        seg_src[0].target     = pred_target_in;
        seg_src[0].bht        = bht_in;
        seg_src[0].pred_taken = pred_taken_in;
        seg_src[0].valid      = valid_in;
        for (int k = 1; k < DEPTH; k++) begin
            seg_src[k] = seg_q[k-1];
        end
    end

    // Stage registers: reset clears, bubble holds (ignoring flush), flush clears, else advance.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rst) begin
                seg_q[k] <= '0;
            end else if (bubble[k]) begin
                seg_q[k] <= seg_q[k];
            end else if (flush[k]) begin
                seg_q[k] <= '0;
            end else begin
                seg_q[k] <= seg_src[k];
            end
        end
    end

    assign tail            = seg_q[TAIL];
    assign pc_out          = tail.pc;
    assign valid_out       = tail.valid;
    assign pred_taken_out  = tail.pred_taken;
    assign pred_target_out = tail.target;
    assign bht_out         = tail.bht;

    // Only a real instruction being resolved is checked; a target mismatch matters only when taken.
    assign chk         = br_resolve & tail.valid;
    assign mispredict  = chk & ((tail.pred_taken != br_taken) |
                                (br_taken & (tail.target != br_target)));
    assign redirect_pc = br_taken ? br_target : tail.pc + PC_W'(4);

    // Saturating BHT counter update, passed through unchanged when nothing is resolved.
    always_comb begin
        bht_next = tail.bht;
        if (chk) begin
            if (br_taken) begin
                if (tail.bht != BHT_MAX) begin
                    bht_next = tail.bht + 1'b1;
                end
            end else if (tail.bht != '0) begin
                bht_next = tail.bht - 1'b1;
            end
        end
    end

    // A held tail is not consumed, so the same resolution is counted only on the edge it leaves.
    assign consume = chk & ~bubble[TAIL] & ~rst;

    // Statistics counters, each saturating independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else if (consume) begin
            if (br_cnt != CNT_MAX) begin
                br_cnt <= br_cnt + 1'b1;
            end
            if (mispredict && (miss_cnt != CNT_MAX)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

endmodule
